// File: rtl/direct_param_loader.sv
// direct_param_loader: parses framed UART bytes into shadow registers and commits them to the direct-word path
module direct_param_loader #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1200000,
    parameter logic [7:0]  HEADER         = 8'hA5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        param_wen,
    output logic [31:0] direct_fword,
    output logic [31:0] direct_pword,
    output logic [31:0] direct_amp,
    output logic [2:0]  direct_en,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_count
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, CHK, EXEC} state_t;
    state_t      state;
    logic [7:0]  addr, csum;
    logic [31:0] data, gap, shadow_f, shadow_p, shadow_a;
    logic [2:0]  shadow_en;
    logic [1:0]  cnt;
    logic        known, good;
    always_comb begin
        known = addr == 8'h01 || addr == 8'h02 || addr == 8'h03 || addr == 8'h04 || addr == 8'h10;
        good  = rx_data == csum && known;
    end
    // The frame is executed on the CHK-byte edge so results are visible during the EXEC cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            addr         <= '0;
            csum         <= '0;
            data         <= '0;
            gap          <= '0;
            cnt          <= '0;
            shadow_f     <= '0;
            shadow_p     <= '0;
            shadow_a     <= '0;
            shadow_en    <= '0;
            param_wen    <= 1'b0;
            direct_fword <= '0;
            direct_pword <= '0;
            direct_amp   <= '0;
            direct_en    <= '0;
            frame_ok     <= 1'b0;
            frame_err    <= 1'b0;
            err_count    <= '0;
        end else begin
            param_wen <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (rx_valid && rx_data == HEADER) begin
                    state <= ADDR;
                    gap   <= '0;
                end
                EXEC: state <= IDLE;
                default: if (rx_valid) begin
                    gap <= '0;
                    if (state == ADDR) begin
                        addr  <= rx_data;
                        csum  <= rx_data;
                        cnt   <= '0;
                        state <= DATA;
                    end else if (state == DATA) begin
                        data  <= {data[23:0], rx_data};
                        csum  <= csum ^ rx_data;
                        cnt   <= cnt + 2'd1;
                        state <= cnt == 2'd3 ? CHK : DATA;
                    end else begin
                        state     <= EXEC;
                        frame_ok  <= good;
                        frame_err <= !good;
                        if (!good)
                            err_count <= err_count + {7'd0, err_count != 8'hFF};
                        else if (addr == 8'h01)
                            shadow_f <= data;
                        else if (addr == 8'h02)
                            shadow_p <= data;
                        else if (addr == 8'h03)
                            shadow_a <= data;
                        else if (addr == 8'h04)
                            shadow_en <= data[2:0];
                        else begin
                            direct_fword <= shadow_f;
                            direct_pword <= shadow_p;
                            direct_amp   <= shadow_a;
                            direct_en    <= shadow_en;
                            param_wen    <= 1'b1;
                        end
                    end
                end else if (gap == TIMEOUT_CYCLES - 32'd1) begin
                    gap       <= '0;
                    state     <= IDLE;
                    frame_err <= 1'b1;
                    err_count <= err_count + {7'd0, err_count != 8'hFF};
                end else begin
                    gap <= gap + 32'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_direct_param_loader.sv
// tb_direct_param_loader: randomized frame stimulus checked against a transaction-level register model
module tb_direct_param_loader;
    localparam int T = 16;
    localparam logic [7:0] HDR = 8'hA5;
    logic        clk = 1'b0, rstn = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        param_wen, frame_ok, frame_err;
    logic [31:0] direct_fword, direct_pword, direct_amp;
    logic [2:0]  direct_en;
    logic [7:0]  err_count;
    int n_checks = 0, n_fail = 0;
    logic [31:0] m_sf = 0, m_sp = 0, m_sa = 0, m_f = 0, m_p = 0, m_a = 0;
    logic [2:0]  m_se = 0, m_e = 0;
    logic [7:0]  m_err = 0;

    direct_param_loader #(.TIMEOUT_CYCLES(T), .HEADER(HDR)) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
        .param_wen(param_wen), .direct_fword(direct_fword), .direct_pword(direct_pword),
        .direct_amp(direct_amp), .direct_en(direct_en), .frame_ok(frame_ok),
        .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic check_state(input string tag, input logic [2:0] pulses);
        n_checks++;
        if ({frame_ok, frame_err, param_wen} !== pulses) begin
            n_fail++;
            $display("FAIL %s pulses ok/err/wen: got %b exp %b", tag, {frame_ok, frame_err, param_wen}, pulses);
        end
        n_checks++;
        if ({direct_fword, direct_pword, direct_amp, direct_en} !== {m_f, m_p, m_a, m_e}) begin
            n_fail++;
            $display("FAIL %s outputs: got %h %h %h %b exp %h %h %h %b", tag,
                     direct_fword, direct_pword, direct_amp, direct_en, m_f, m_p, m_a, m_e);
        end
        n_checks++;
        if (err_count !== m_err) begin
            n_fail++;
            $display("FAIL %s err_count: got %0d exp %0d", tag, err_count, m_err);
        end
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [31:0] d, input logic bad);
        logic [7:0] chk;
        logic ok, wen;
        chk = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        if (bad) chk = chk ^ (8'd1 << $urandom_range(0, 7));
        send_byte(HDR);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        send_byte(a);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_byte(d[8*(3-i) +: 8]);
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        send_byte(chk);
        ok  = !bad && (a inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h10});
        wen = ok && a == 8'h10;
        if (ok) begin
            case (a)
                8'h01: m_sf = d;
                8'h02: m_sp = d;
                8'h03: m_sa = d;
                8'h04: m_se = d[2:0];
                default: begin m_f = m_sf; m_p = m_sp; m_a = m_sa; m_e = m_se; end
            endcase
        end else if (m_err != 8'hFF) m_err = m_err + 8'd1;
        check_state($sformatf("frame a=%h", a), {ok, !ok, wen});
        @(negedge clk);
        check_state($sformatf("after a=%h", a), 3'b000);
    endtask

    task automatic model_reset;
        {m_sf, m_sp, m_sa, m_f, m_p, m_a} = '0;
        {m_se, m_e, m_err} = '0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_state("reset", 3'b000);
        rstn = 1'b1;
        @(negedge clk);
        check_state("reset_release", 3'b000);
    endtask

    task automatic test_fword_commit;
        do_frame(8'h01, 32'h12345678, 1'b0);
        do_frame(8'h10, 32'h0, 1'b0);
    endtask

    task automatic test_all_regs;
        do_frame(8'h02, 32'h80000000, 1'b0);
        do_frame(8'h03, 32'h00000FFF, 1'b0);
        do_frame(8'h04, 32'h00000005, 1'b0);
        do_frame(8'h10, 32'($urandom), 1'b0);
    endtask

    task automatic test_bad_checksum;
        do_frame(8'h02, 32'h00000001, 1'b1);
        do_frame(8'h10, 32'h0, 1'b0);
    endtask

    task automatic test_unknown_and_junk;
        do_frame(8'h07, 32'h0, 1'b0);
        send_byte(8'h00);
        check_state("junk00", 3'b000);
        send_byte(8'hFF);
        check_state("junkFF", 3'b000);
        do_frame(8'h01, 32'($urandom), 1'b0);
    endtask

    task automatic test_timeout;
        int first;
        first = 0;
        send_byte(HDR);
        send_byte(8'h01);
        send_byte(8'h12);
        for (int c = 1; c <= T + 4; c++) begin
            @(negedge clk);
            if (frame_err === 1'b1 && first == 0) first = c;
        end
        n_checks++;
        if (first != T) begin
            n_fail++;
            $display("FAIL timeout cycle: got %0d exp %0d", first, T);
        end
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
        check_state("timeout_after", 3'b000);
        do_frame(8'h03, 32'($urandom), 1'b0);
        do_frame(8'h10, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_frame;
        send_byte(HDR);
        send_byte(8'h01);
        send_byte(8'h12);
        rstn = 1'b0;
        @(negedge clk);
        model_reset();
        check_state("mid_reset", 3'b000);
        rstn = 1'b1;
        repeat (T + 2) @(negedge clk);
        check_state("mid_reset_idle", 3'b000);
        do_frame(8'h01, 32'($urandom), 1'b0);
        do_frame(8'h10, 32'h0, 1'b0);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) do_frame(8'h01, 32'($urandom), 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0: a = 8'h01;
                1: a = 8'h02;
                2: a = 8'h03;
                3: a = 8'h04;
                4, 5: a = 8'h10;
                default: a = 8'($urandom);
            endcase
            do_frame(a, 32'($urandom), $urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_fword_commit();
        test_all_regs();
        test_bad_checksum();
        test_unknown_and_junk();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
